block_arbiter: RTL and testbench
================================

BLOCK_ARBITER -- requirements
Module: block_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of cache requesters (only 2 is supported).
REQ-002 Parameter BLKWORDS, default 2, words per block transfer (only 2 is supported).
REQ-003 CLK  in  1  single clock, rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 cREN  in  [NREQ]  per-requester block read request.
REQ-006 cWEN  in  [NREQ]  per-requester block write (writeback) request.
REQ-007 caddr  in  [NREQ] x word_t  per-requester byte address; bits [2:0] are ignored.
REQ-008 cstore  in  [NREQ] x word_t  per-requester store data for the word selected by woff.
REQ-009 cwait  out  [NREQ]  per-requester wait; low for exactly the cycle in which a word completes.
REQ-010 cload  out  word_t  ramload broadcast to all requesters.
REQ-011 gnt  out  [NREQ]  one-hot grant; all zero when no transfer is active.
REQ-012 woff  out  1  word offset of the current beat (0 = base, 1 = base+4).
REQ-013 ramstate  in  ramstate_t  FREE, BUSY, ACCESS or ERROR.
REQ-014 ramload  in  word_t  RAM read data.
REQ-015 ramaddr, ramstore  out  word_t  RAM address and write data.
REQ-016 ramREN, ramWEN  out  1  RAM read and write strobes; never both high.

Function
REQ-017 The FSM states SHALL be IDLE, BEAT0, BEAT1 and RELEASE.
REQ-018 IDLE: when any cREN|cWEN is high, the arbiter SHALL latch the winner into gnt and the write/read type, then enter BEAT0 on the next edge; with no request it SHALL stay in IDLE.
REQ-019 Winner selection SHALL be round-robin: the requester not named by the priority pointer wins only if the pointed-to requester is idle.
REQ-020 If one requester asserts cWEN and cREN together, the transfer SHALL be a write.
REQ-021 BEAT0/BEAT1: ramaddr SHALL be {caddr[g][31:3], woff, 2'b00}, ramstore SHALL be cstore[g], and ramWEN/ramREN SHALL follow the latched type, where g is the granted requester.
REQ-022 When ramstate==ACCESS, cwait[g] SHALL go low combinationally in that cycle; BEAT0 then advances to BEAT1 and BEAT1 advances to RELEASE.
REQ-023 When ramstate is FREE, BUSY or ERROR, the FSM SHALL hold its state and cwait SHALL stay high (ERROR causes a retry of the same beat).
REQ-024 If the granted requester drops both cREN and cWEN in BEAT0 or BEAT1 before ACCESS, the FSM SHALL return to IDLE and the pointer SHALL not change.
REQ-025 RELEASE SHALL last one cycle with no RAM strobe, gnt cleared and the pointer set to the requester that did not finish the transfer; the FSM then returns to IDLE.
REQ-026 Non-granted requesters SHALL see cwait high throughout.
REQ-027 woff SHALL be 0 in BEAT0 and 1 in BEAT1; outside those states, woff and all RAM outputs SHALL be 0.
REQ-028 Minimum block latency SHALL be 4 cycles from request to the next IDLE, with zero RAM wait states.

Reset
REQ-029 While nRST is low, the FSM SHALL be in IDLE, the pointer SHALL be 0, gnt, woff, ramREN, ramWEN, ramaddr and ramstore SHALL be 0, and cwait SHALL be all ones.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer immediately, with no further RAM strobe.

Structure
REQ-031 The arbstate_t enum SHALL live in cpu_types_pkg next to ramstate_t and word_t.
REQ-032 Round-robin selection SHALL be a sub-module rr_pick2 (inputs: req[1:0] and ptr; output: one-hot grant).

Verification
REQ-033 Requester 0 reads 0x40 with ramstate ACCESS each cycle -> ramaddr 0x40 then 0x44, cwait[0] low in two consecutive cycles, RELEASE, IDLE 4 cycles after request.
REQ-034 Both requesters request reads at 0x100 and 0x200 simultaneously after reset -> requester 0 served first, then requester 1, gnt sequence 01, 00, 10.
REQ-035 Requester 1 sets cWEN and cREN together at 0x80 with cstore 0xDEAD then 0xBEEF -> ramWEN only, ramstore 0xDEAD@0x80 and 0xBEEF@0x84.
REQ-036 ramstate BUSY for 3 cycles then ERROR for 1 cycle then ACCESS in BEAT0 -> ramaddr held, cwait high for 4 cycles, beat completes on ACCESS.
REQ-037 Requester 0 drops its request in BEAT1 before ACCESS -> return to IDLE, pointer still 0; nRST pulsed in BEAT0 -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: data word, RAM handshake state and the
// block arbiter's FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BEAT0   = 2'd1,
        BEAT1   = 2'd2,
        RELEASE = 2'd3
    } arbstate_t;

    localparam int unsigned ARB_NREQ     = 2;
    localparam int unsigned ARB_BLKWORDS = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: the requester named by ptr has priority,
// the other one wins only when the pointed-to requester is idle.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    logic other;

    assign other = ~ptr;

    always_comb begin
        gnt = 2'b00;
        if (req[ptr]) begin
            gnt[ptr] = 1'b1;
        end else if (req[other]) begin
            gnt[other] = 1'b1;
        end
    end

endmodule

// File: rtl/block_arbiter.sv
// Arbitrates two cache requesters onto one word-wide RAM port, moving a
// two-word block per grant (BEAT0, BEAT1) followed by a one-cycle RELEASE.
// Handshake: a beat completes only in a cycle where the granted requester
// still requests and ramstate==ACCESS; cwait[g] is low in exactly that cycle.
module block_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREQ     = ARB_NREQ,
    parameter int unsigned BLKWORDS = ARB_BLKWORDS
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NREQ-1:0]   cREN,
    input  logic [NREQ-1:0]   cWEN,
    input  word_t             caddr  [NREQ],
    input  word_t             cstore [NREQ],
    output logic [NREQ-1:0]   cwait,
    output word_t             cload,
    output logic [NREQ-1:0]   gnt,
    output logic              woff,
    input  ramstate_t         ramstate,
    input  word_t             ramload,
    output word_t             ramaddr,
    output word_t             ramstore,
    output logic              ramREN,
    output logic              ramWEN,
    output arbstate_t         dbg_state_o,
    output logic              dbg_ptr_o
);

    if (NREQ != 2 || BLKWORDS != 2) begin : g_param_check
        $error("block_arbiter supports only NREQ=2 and BLKWORDS=2");
    end

    arbstate_t  state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       gidx_q, gidx_d;
    logic       wr_q, wr_d;
    logic       ptr_q, ptr_d;

    logic [1:0] req;
    logic [1:0] pick;
    logic       in_beat;
    logic       beat1;
    logic       still_req;
    word_t      sel_addr;

    // Sub-word address bits never reach the RAM; blocks are 8-byte aligned.
    logic [5:0] unused_addr_bits;
    assign unused_addr_bits = {caddr[1][2:0], caddr[0][2:0]};

    assign req       = cREN | cWEN;
    assign in_beat   = (state_q == BEAT0) || (state_q == BEAT1);
    assign beat1     = (state_q == BEAT1);
    assign still_req = req[gidx_q];
    assign sel_addr  = caddr[gidx_q];

    rr_pick2 u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            gidx_q  <= 1'b0;
            wr_q    <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            wr_q    <= wr_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        wr_d    = wr_q;
        ptr_d   = ptr_q;
        cwait   = '1;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    gidx_d  = pick[1];
                    // A requester raising both strobes is writing back.
                    wr_d    = |(pick & cWEN);
                    state_d = BEAT0;
                end
            end
            BEAT0, BEAT1: begin
                if (!still_req) begin
                    // Abandoned before completion: pointer deliberately untouched.
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end else if (ramstate == ACCESS) begin
                    cwait[gidx_q] = 1'b0;
                    if (beat1) begin
                        state_d = RELEASE;
                        gnt_d   = 2'b00;
                    end else begin
                        state_d = BEAT1;
                    end
                end
            end
            RELEASE: begin
                ptr_d   = ~gidx_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // RAM side is decoded from the registered state so reset silences it at once.
    always_comb begin
        woff     = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        if (in_beat) begin
            woff     = beat1;
            ramaddr  = {sel_addr[31:3], beat1, 2'b00};
            ramstore = cstore[gidx_q];
            ramWEN   = wr_q;
            ramREN   = ~wr_q;
        end
    end

    assign gnt         = gnt_q;
    assign cload       = ramload;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_block_arbiter.sv
// Directed bench for block_arbiter: a per-cycle vector table for the main
// arbitration traffic plus hand-written wait-state, abort and reset sequences.
module tb_block_arbiter;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic [1:0] cREN;
  logic [1:0] cWEN;
  word_t      caddr [2];
  word_t      cstore [2];
  logic [1:0] cwait;
  word_t      cload;
  logic [1:0] gnt;
  logic       woff;
  ramstate_t  ramstate;
  word_t      ramload;
  word_t      ramaddr;
  word_t      ramstore;
  logic       ramREN;
  logic       ramWEN;
  arbstate_t  dbg_state_o;
  logic       dbg_ptr_o;

  int errors = 0;
  int checks = 0;

  block_arbiter dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .cREN        (cREN),
    .cWEN        (cWEN),
    .caddr       (caddr),
    .cstore      (cstore),
    .cwait       (cwait),
    .cload       (cload),
    .gnt         (gnt),
    .woff        (woff),
    .ramstate    (ramstate),
    .ramload     (ramload),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .dbg_state_o (dbg_state_o),
    .dbg_ptr_o   (dbg_ptr_o)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] cren;
    logic [1:0] cwen;
    ramstate_t  rs;
    word_t      a0;
    word_t      a1;
    word_t      s0;
    word_t      s1;
    arbstate_t  e_state;
    logic [1:0] e_gnt;
    logic       e_woff;
    logic       e_ren;
    logic       e_wen;
    logic [1:0] e_cwait;
    word_t      e_addr;
    word_t      e_store;
    logic       e_ptr;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_outs(input string tag, input arbstate_t st, input logic [1:0] g,
                          input logic wo, input logic ren, input logic wen,
                          input logic [1:0] cw, input word_t addr, input word_t store);
    chk({tag, ".state"}, 32'(dbg_state_o), 32'(st));
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".woff"}, 32'(woff), 32'(wo));
    chk({tag, ".ramREN"}, 32'(ramREN), 32'(ren));
    chk({tag, ".ramWEN"}, 32'(ramWEN), 32'(wen));
    chk({tag, ".cwait"}, 32'(cwait), 32'(cw));
    chk({tag, ".ramaddr"}, ramaddr, addr);
    chk({tag, ".ramstore"}, ramstore, store);
  endtask

  task automatic drive(input logic [1:0] cren, input logic [1:0] cwen, input ramstate_t rs);
    cREN     = cren;
    cWEN     = cwen;
    ramstate = rs;
  endtask

  initial begin
    int wait_high;

    // vector table: inputs applied in a cycle, outputs expected in that same cycle
    //          cren   cwen   rs      a0        a1        s0     s1        state    gnt    wo    ren   wen   cwait  addr      store     ptr
    vecs[0]  = '{2'b11, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    IDLE,    2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b0};
    vecs[1]  = '{2'b11, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    BEAT0,   2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0,    1'b0};
    vecs[2]  = '{2'b11, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    BEAT1,   2'b01, 1'b1, 1'b1, 1'b0, 2'b10, 32'h104, 32'h0,    1'b0};
    vecs[3]  = '{2'b11, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    RELEASE, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b0};
    vecs[4]  = '{2'b11, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    IDLE,    2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b1};
    vecs[5]  = '{2'b11, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    BEAT0,   2'b10, 1'b0, 1'b1, 1'b0, 2'b01, 32'h200, 32'h0,    1'b1};
    vecs[6]  = '{2'b11, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    BEAT1,   2'b10, 1'b1, 1'b1, 1'b0, 2'b01, 32'h204, 32'h0,    1'b1};
    vecs[7]  = '{2'b00, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    RELEASE, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b1};
    vecs[8]  = '{2'b00, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    IDLE,    2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b0};
    vecs[9]  = '{2'b00, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    IDLE,    2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b0};
    vecs[10] = '{2'b01, 2'b00, ACCESS, 32'h107, 32'h200, 32'h0, 32'h0,    IDLE,    2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b0};
    vecs[11] = '{2'b01, 2'b00, ACCESS, 32'h107, 32'h200, 32'h0, 32'h0,    BEAT0,   2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h0,    1'b0};
    vecs[12] = '{2'b01, 2'b00, ACCESS, 32'h107, 32'h200, 32'h0, 32'h0,    BEAT1,   2'b01, 1'b1, 1'b1, 1'b0, 2'b10, 32'h104, 32'h0,    1'b0};
    vecs[13] = '{2'b00, 2'b00, ACCESS, 32'h107, 32'h200, 32'h0, 32'h0,    RELEASE, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b0};
    vecs[14] = '{2'b00, 2'b00, ACCESS, 32'h100, 32'h200, 32'h0, 32'h0,    IDLE,    2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b1};
    vecs[15] = '{2'b10, 2'b10, ACCESS, 32'h100, 32'h80,  32'h0, 32'hDEAD, IDLE,    2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b1};
    vecs[16] = '{2'b10, 2'b10, ACCESS, 32'h100, 32'h80,  32'h0, 32'hDEAD, BEAT0,   2'b10, 1'b0, 1'b0, 1'b1, 2'b01, 32'h80,  32'hDEAD, 1'b1};
    vecs[17] = '{2'b10, 2'b10, ACCESS, 32'h100, 32'h80,  32'h0, 32'hBEEF, BEAT1,   2'b10, 1'b1, 1'b0, 1'b1, 2'b01, 32'h84,  32'hBEEF, 1'b1};
    vecs[18] = '{2'b00, 2'b00, ACCESS, 32'h100, 32'h80,  32'h0, 32'h0,    RELEASE, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b1};
    vecs[19] = '{2'b00, 2'b00, ACCESS, 32'h100, 32'h80,  32'h0, 32'h0,    IDLE,    2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0,   32'h0,    1'b0};

    // reset: outputs must be at reset values while nRST is low, even with traffic
    nRST      = 1'b1;
    cREN      = 2'b00;
    cWEN      = 2'b00;
    caddr[0]  = 32'h0;
    caddr[1]  = 32'h0;
    cstore[0] = 32'h0;
    cstore[1] = 32'h0;
    ramstate  = FREE;
    ramload   = 32'h0;
    #2;
    nRST = 1'b0;
    drive(2'b11, 2'b00, ACCESS);
    #1;
    chk_outs("reset", IDLE, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    chk("reset.ptr", 32'(dbg_ptr_o), 32'h0);
    tick();
    tick();
    chk_outs("reset_held", IDLE, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    drive(2'b00, 2'b00, FREE);
    #3;
    nRST = 1'b1;

    // table-driven arbitration, single-requester block and combined write
    for (int i = 0; i < 20; i++) begin
      tick();
      drive(vecs[i].cren, vecs[i].cwen, vecs[i].rs);
      caddr[0]  = vecs[i].a0;
      caddr[1]  = vecs[i].a1;
      cstore[0] = vecs[i].s0;
      cstore[1] = vecs[i].s1;
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_gnt, vecs[i].e_woff,
               vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_cwait, vecs[i].e_addr, vecs[i].e_store);
      chk($sformatf("vec%0d.ptr", i), 32'(dbg_ptr_o), 32'(vecs[i].e_ptr));
    end

    // requester 0 abandons its request in BEAT1 before ACCESS
    caddr[0]  = 32'h40;
    cstore[1] = 32'h0;
    tick(); drive(2'b01, 2'b00, BUSY); #1;
    chk("abort.idle", 32'(dbg_state_o), 32'(IDLE));
    tick(); drive(2'b01, 2'b00, ACCESS); #1;
    chk("abort.b0_cwait", 32'(cwait), 32'h2);
    tick(); drive(2'b01, 2'b00, BUSY); #1;
    chk_outs("abort.b1_busy", BEAT1, 2'b01, 1'b1, 1'b1, 1'b0, 2'b11, 32'h44, 32'h0);
    tick(); drive(2'b00, 2'b00, BUSY); #1;
    chk("abort.drop_cwait", 32'(cwait), 32'h3);
    tick(); #1;
    chk("abort.back_idle", 32'(dbg_state_o), 32'(IDLE));
    chk("abort.gnt", 32'(gnt), 32'h0);
    chk("abort.ptr", 32'(dbg_ptr_o), 32'h0);

    // BUSY x3, ERROR x1, then ACCESS in BEAT0
    tick(); drive(2'b01, 2'b00, ACCESS); #1;
    chk("ws.idle", 32'(dbg_state_o), 32'(IDLE));
    wait_high = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(2'b01, 2'b00, (c < 3) ? BUSY : ERROR);
      #1;
      chk_outs($sformatf("ws.stall%0d", c), BEAT0, 2'b01, 1'b0, 1'b1, 1'b0, 2'b11, 32'h40, 32'h0);
      if (cwait[0]) wait_high++;
    end
    chk("ws.cwait_high_cycles", 32'(wait_high), 32'd4);
    tick(); drive(2'b01, 2'b00, ACCESS); #1;
    chk_outs("ws.b0_access", BEAT0, 2'b01, 1'b0, 1'b1, 1'b0, 2'b10, 32'h40, 32'h0);
    tick(); #1;
    chk_outs("ws.b1_access", BEAT1, 2'b01, 1'b1, 1'b1, 1'b0, 2'b10, 32'h44, 32'h0);
    tick(); drive(2'b00, 2'b00, FREE); #1;
    chk("ws.release", 32'(dbg_state_o), 32'(RELEASE));
    tick(); #1;
    chk("ws.idle_after", 32'(dbg_state_o), 32'(IDLE));
    chk("ws.ptr", 32'(dbg_ptr_o), 32'h1);

    // reset pulsed during BEAT0 aborts immediately
    tick(); drive(2'b01, 2'b00, BUSY); #1;
    tick(); #1;
    chk("rst_mid.in_beat0", 32'(dbg_state_o), 32'(BEAT0));
    chk("rst_mid.ren_before", 32'(ramREN), 32'h1);
    nRST = 1'b0;
    #1;
    chk_outs("rst_mid.same_cycle", IDLE, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    chk("rst_mid.ptr", 32'(dbg_ptr_o), 32'h0);
    tick();
    chk("rst_mid.no_strobe", 32'({ramREN, ramWEN}), 32'h0);
    drive(2'b00, 2'b00, FREE);
    #3;
    nRST = 1'b1;
    tick(); #1;
    chk("rst_mid.idle", 32'(dbg_state_o), 32'(IDLE));

    // ramload is broadcast unchanged
    ramload = 32'h1234_5678;
    #1;
    chk("cload", cload, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // safety net against a stuck simulation
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
